aes_inv_key_sched: RTL and testbench
====================================

# aes_inv_key_sched

Sequential inverse key-schedule generator for the AES-128 decryption datapath. Takes the final (round-10) round key and walks the key expansion backwards, emitting round keys 10, 9, …, 0, one per accepted handshake. It sits directly upstream of the decryption round core and drives that core's `round_key` input in lock-step with the round being processed.

## Interface
Parameters:
- `NR`, default 10: number of AES rounds. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low (`clk`, `rst_n`).
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  capture `last_key` and begin a sequence. Sampled only in IDLE.
- `last_key`  in  128  round-10 key, FIPS-197 byte order. Byte 0 is `[127:120]`; word k0 is `[127:96]`.
- `round_key`  out  128  currently offered round key.
- `round_idx`  out  4  index of `round_key`, from 10 down to 0.
- `key_valid`  out  1  `round_key` and `round_idx` are valid.
- `key_ready`  in  1  consumer accepts the key this cycle.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after round 0 is accepted.

## Operation
- State machine:
  - IDLE: `key_valid`=0, `busy`=0. On `start`=1, load key_reg←`last_key` and round←10, then go to EMIT.
  - EMIT: `key_valid`=1, `busy`=1.
    - Handshake (`key_valid & key_ready`) with round>0: key_reg←prev(key_reg, round), round←round−1, stay in EMIT.
    - Handshake with round==0: go to IDLE and assert `done` for one cycle.
    - No handshake: hold key_reg and round unchanged.
- Backward step prev(k, r), with k = {k0, k1, k2, k3} in 32-bit words:
  - p3 = k3^k2.
  - p2 = k2^k1.
  - p1 = k1^k0.
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[r], 24'h0}.
  - Result is {p0, p1, p2, p3}.
- RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies the forward S-box to each byte.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- `start` in EMIT is ignored; there is no restart mid-sequence.
- `start` on the same cycle that `done` is asserted (state already IDLE) is accepted normally.
- `last_key` is sampled only on the accepting `start` cycle. Later changes have no effect.
- `key_ready` while `key_valid`=0 is ignored.

## Timing
- Reset values: state=IDLE, `round_key`=0, `round_idx`=0, `key_valid`=0, `busy`=0, `done`=0.
- Reset asserted mid-sequence: on the next edge, return to IDLE with all outputs at reset values. No `done` pulse.
- All outputs are registered. `round_key` is key_reg directly; there is no combinational path from `key_ready` to outputs.
- Latency: `start` sampled at edge N gives `key_valid`=1 with round 10 after edge N (visible cycle N+1).
- With `key_ready` held high, keys 10..0 are delivered on 11 consecutive cycles. `done` is high in the cycle after the round-0 handshake; that cycle is 12 cycles after start acceptance.
- The backward step is a single-cycle combinational path: 4 S-box lookups plus XORs. No multicycle paths.
- `round_idx` decrements by exactly 1 per handshake and never wraps below 0.

## Structure
- Shared package `constant`:
  - Forward `sbox[0:255]`, added alongside the existing `inv_sbox`.
  - `rcon[1:10]` bytes.
  - AES-128 constants: NR=10, key width 128.
- Sub-module `aes_sub_word`: 32-bit combinational SubWord using `constant.sbox`. One instance.
- The FSM, key register and round counter live in the top module. Target is about 150–250 lines total.

## Test plan
- FIPS-197 A.1 sequence: `last_key`=d014f9a8c9ee2589e13f0cc8b6630ca6, `key_ready`=1.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Round 9 = ac7766f319fadc2128d12941575c006e.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - `done` pulses at cycle 12.
- Backpressure: same key, random `key_ready` (≈50% duty).
  - Identical 11-key sequence is produced.
  - `round_key` and `round_idx` are stable whenever valid & !ready.
  - No key is skipped or duplicated.
- `start` re-asserted in EMIT with a different `last_key`: ignored; the original sequence completes unchanged.
- `rst_n`=0 while `round_idx`=5: next cycle `key_valid`=0, `busy`=0, `round_key`=0, and no `done` pulse. A fresh `start` then restarts at round 10.
- Back-to-back runs: `start` asserted in the `done` cycle with `last_key`=13111d7fe3944a17f307a78b4d2b30c5 (FIPS-197 C.1). The second run's round 0 = 000102030405060708090a0b0c0d0e0f.
- Reset values: hold `rst_n`=0 for 3 cycles while `start`=1. All outputs stay 0, and no sequence begins until the first `start` after release.

Source files
------------

// File: rtl/aes_inv_key_sched_pkg.sv
// Shared AES-128 constants for the inverse key schedule: forward S-box,
// round constants and the controller state encoding.
package aes_inv_key_sched_pkg;

  localparam int NR_AES128 = 10;
  localparam int KEY_W     = 128;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Rounds outside 1..10 never step backwards; they map to a zero constant.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd10) return RCON[r];
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: forward S-box applied independently to each byte of a 32-bit word.
module aes_sub_word
  import aes_inv_key_sched_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  assign sub[31:24] = SBOX[word[31:24]];
  assign sub[23:16] = SBOX[word[23:16]];
  assign sub[15:8]  = SBOX[word[15:8]];
  assign sub[7:0]   = SBOX[word[7:0]];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: starting from the round-10 key, walks the
// expansion backwards and offers round keys 10..0 over a valid/ready handshake.
module aes_inv_key_sched
  import aes_inv_key_sched_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] last_key,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_idx,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t           state, state_next;
  logic [KEY_W-1:0] key_reg;
  logic [3:0]       round;
  logic             handshake;
  logic             last_accept;
  logic [31:0]      k0, k1, k2, k3;
  logic [31:0]      p0, p1, p2, p3;
  logic [31:0]      rot_word, sub_word;
  logic [KEY_W-1:0] key_prev;

  assign handshake   = (state == EMIT) && key_ready;
  assign last_accept = handshake && (round == 4'd0);

  // Backward step: recover the previous round key from the current one.
  assign {k0, k1, k2, k3} = key_reg;
  assign p3       = k3 ^ k2;
  assign p2       = k2 ^ k1;
  assign p1       = k1 ^ k0;
  assign rot_word = {p3[23:0], p3[31:24]};

  aes_sub_word u_sub_word (
    .word (rot_word),
    .sub  (sub_word)
  );

  assign p0       = k0 ^ sub_word ^ {rcon_of(round), 24'h0};
  assign key_prev = {p0, p1, p2, p3};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EMIT;
      EMIT:    if (last_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    key_valid = (state == EMIT);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_reg <= '0;
      round   <= 4'd0;
      done    <= 1'b0;
    end else begin
      done <= last_accept;
      if (state == IDLE && start) begin
        key_reg <= last_key;
        round   <= LAST_ROUND;
      end else if (handshake && round != 4'd0) begin
        key_reg <= key_prev;
        round   <= round - 4'd1;
      end
    end
  end

  assign round_key = key_reg;
  assign round_idx = round;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using FIPS-197 vectors and a forward
// key-expansion reference.
module tb_aes_inv_key_sched;
  import aes_inv_key_sched_pkg::*;

  localparam logic [127:0] A1_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A1_R9   = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1_LAST = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_R0   = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] last_key;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  int passed;
  int total;
  logic [127:0] exp_keys [0:10];

  aes_inv_key_sched #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .last_key  (last_key),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", passed, total);
    $fatal(1, "watchdog expired");
  end

  // Forward expansion from the round-0 key fills exp_keys[0..10].
  task automatic build_exp(input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    exp_keys[0] = k;
    for (int r = 1; r <= 10; r++) begin
      t  = {w3[23:0], w3[31:24]};
      t  = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {RCON[r], 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      exp_keys[r] = {w0, w1, w2, w3};
    end
  endtask

  // Pulse start for one edge; returns at the negedge where round 10 is visible.
  task automatic kick(input logic [127:0] k);
    @(negedge clk);
    last_key = k;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    last_key = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; last_key = A1_LAST; key_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({round_key, round_idx, key_valid, busy, done} !== '0)
        $display("FAIL reset_outputs cycle %0d: got key=%h idx=%0d vld=%b busy=%b done=%b, want all zero",
                 c, round_key, round_idx, key_valid, busy, done);
      else passed++;
    end
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (key_valid !== 1'b0 || busy !== 1'b0 || round_key !== '0)
      $display("FAIL idle_after_release: got vld=%b busy=%b key=%h, want 0 0 0", key_valid, busy, round_key);
    else passed++;
  endtask

  task automatic test_fips_a1;
    build_exp(A1_R0);
    key_ready = 1'b1;
    kick(A1_LAST);
    for (int k = 1; k <= 11; k++) begin
      int r;
      r = 11 - k;
      total++;
      if (key_valid !== 1'b1 || round_idx !== r[3:0] || done !== 1'b0 || busy !== 1'b1)
        $display("FAIL a1_ctrl cycle %0d: got vld=%b idx=%0d done=%b busy=%b, want 1 %0d 0 1",
                 k, key_valid, round_idx, done, busy, r);
      else passed++;
      total++;
      if (round_key !== exp_keys[r])
        $display("FAIL a1_key round %0d: got %h want %h", r, round_key, exp_keys[r]);
      else passed++;
      if (r == 10 || r == 9 || r == 1 || r == 0) begin
        logic [127:0] fixed;
        fixed = (r == 10) ? A1_LAST : (r == 9) ? A1_R9 : (r == 1) ? A1_R1 : A1_R0;
        total++;
        if (round_key !== fixed)
          $display("FAIL a1_fips round %0d: got %h want %h", r, round_key, fixed);
        else passed++;
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || key_valid !== 1'b0)
      $display("FAIL a1_done cycle 12: got done=%b busy=%b vld=%b, want 1 0 0", done, busy, key_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 1'b0)
      $display("FAIL a1_done_pulse: got done=%b want 0", done);
    else passed++;
  endtask

  task automatic test_backpressure;
    int exp_r;
    bit got_done;
    int stalls;
    build_exp(A1_R0);
    key_ready = 1'b0;
    exp_r = 10; got_done = 1'b0; stalls = 0;
    kick(A1_LAST);
    for (int c = 0; c < 300 && !got_done; c++) begin
      if (exp_r < 0) begin
        total++;
        if (done !== 1'b1)
          $display("FAIL bp_done: got done=%b want 1", done);
        else passed++;
        got_done = 1'b1;
      end else begin
        total++;
        if (key_valid !== 1'b1 || round_idx !== exp_r[3:0] || round_key !== exp_keys[exp_r] || done !== 1'b0)
          $display("FAIL bp_key cycle %0d: got vld=%b idx=%0d key=%h done=%b, want 1 %0d %h 0",
                   c, key_valid, round_idx, round_key, done, exp_r, exp_keys[exp_r]);
        else passed++;
        key_ready = 1'($urandom_range(0, 1));
        if (key_ready) exp_r--;
        else stalls++;
        @(negedge clk);
      end
    end
    total++;
    if (!got_done)
      $display("FAIL bp_timeout: sequence incomplete, next round %0d, want done", exp_r);
    else passed++;
    key_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_in_emit;
    build_exp(A1_R0);
    key_ready = 1'b1;
    kick(A1_LAST);
    for (int k = 0; k <= 10; k++) begin
      int r;
      r = 10 - k;
      total++;
      if (key_valid !== 1'b1 || round_idx !== r[3:0] || round_key !== exp_keys[r])
        $display("FAIL restart_ignored round %0d: got vld=%b idx=%0d key=%h, want 1 %0d %h",
                 r, key_valid, round_idx, round_key, r, exp_keys[r]);
      else passed++;
      if (k >= 1 && k <= 4) begin
        start = 1'b1; last_key = C1_LAST;
      end else begin
        start = 1'b0; last_key = '0;
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1)
      $display("FAIL restart_done: got done=%b want 1", done);
    else passed++;
    @(negedge clk);
    total++;
    if (key_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL restart_idle: got vld=%b busy=%b want 0 0", key_valid, busy);
    else passed++;
  endtask

  task automatic test_reset_mid;
    bit seen;
    build_exp(A1_R0);
    key_ready = 1'b1;
    seen = 1'b0;
    kick(A1_LAST);
    for (int c = 0; c < 20 && !seen; c++) begin
      if (round_idx === 4'd5) seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!seen || round_key !== exp_keys[5])
      $display("FAIL midrst_reach: got idx=%0d key=%h want 5 %h", round_idx, round_key, exp_keys[5]);
    else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({round_key, round_idx, key_valid, busy, done} !== '0)
      $display("FAIL midrst_outputs: got key=%h idx=%0d vld=%b busy=%b done=%b, want all zero",
               round_key, round_idx, key_valid, busy, done);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || key_valid !== 1'b0)
      $display("FAIL midrst_no_done: got done=%b vld=%b want 0 0", done, key_valid);
    else passed++;
    kick(A1_LAST);
    total++;
    if (key_valid !== 1'b1 || round_idx !== 4'd10 || round_key !== A1_LAST)
      $display("FAIL midrst_restart: got vld=%b idx=%0d key=%h want 1 10 %h",
               key_valid, round_idx, round_key, A1_LAST);
    else passed++;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen)
      $display("FAIL midrst_drain: got done=%b want 1 within budget", done);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    build_exp(A1_R0);
    key_ready = 1'b1;
    kick(A1_LAST);
    for (int r = 10; r >= 0; r--) begin
      total++;
      if (key_valid !== 1'b1 || round_key !== exp_keys[r])
        $display("FAIL b2b_first round %0d: got vld=%b key=%h want 1 %h", r, key_valid, round_key, exp_keys[r]);
      else passed++;
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1)
      $display("FAIL b2b_first_done: got done=%b want 1", done);
    else passed++;
    start = 1'b1; last_key = C1_LAST;
    build_exp(C1_R0);
    @(negedge clk);
    start = 1'b0; last_key = '0;
    for (int r = 10; r >= 0; r--) begin
      total++;
      if (key_valid !== 1'b1 || round_idx !== 4'(r) || round_key !== exp_keys[r])
        $display("FAIL b2b_second round %0d: got vld=%b idx=%0d key=%h want 1 %0d %h",
                 r, key_valid, round_idx, round_key, r, exp_keys[r]);
      else passed++;
      if (r == 10 || r == 0) begin
        total++;
        if (round_key !== ((r == 10) ? C1_LAST : C1_R0))
          $display("FAIL b2b_fips round %0d: got %h want %h", r, round_key, (r == 10) ? C1_LAST : C1_R0);
        else passed++;
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1)
      $display("FAIL b2b_second_done: got done=%b want 1", done);
    else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b0; start = 1'b0; key_ready = 1'b0; last_key = '0;
    test_reset;
    test_fips_a1;
    test_backpressure;
    test_start_in_emit;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
